// File: rtl/soma_param_pipe.sv
// soma_param_pipe: add/sub/accumulate datapath feeding a DEPTH-entry
// result FIFO, with valid/ready handshakes on both sides.
module soma_param_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   valid_i,
    output logic                   ready_i,
    input  logic [1:0]             op_i,
    input  logic [WIDTH-1:0]       data1_i,
    input  logic [WIDTH-1:0]       data2_i,
    output logic                   valid_o,
    input  logic                   ready_o,
    output logic [WIDTH:0]         data_out_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_ACC  = 2'b10,
        OP_LOAD = 2'b11
    } op_e;

    op_e             op;
    logic [WIDTH:0]  d1;
    logic [WIDTH:0]  d2;
    logic [WIDTH:0]  acc;
    logic [WIDTH:0]  result;
    logic [WIDTH:0]  mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            push;
    logic            pop;
    logic            acc_we;

    assign op = op_e'(op_i);
    assign d1 = {1'b0, data1_i};
    assign d2 = {1'b0, data2_i};

    // ready_i depends only on occupancy, so a pop never frees a slot
    // for a push in the same cycle.
    assign ready_i = (count != CW'(DEPTH));
    assign valid_o = (count != '0);
    assign count_o = count;
    assign push    = valid_i && ready_i;
    assign pop     = valid_o && ready_o;

    always_comb begin
        result = '0;
        acc_we = 1'b0;
        unique case (op)
            OP_ADD: result = d1 + d2;
            OP_SUB: result = d1 - d2;
            OP_ACC: begin
                result = acc + d1;
                acc_we = 1'b1;
            end
            OP_LOAD: begin
                result = d1 + d2;
                acc_we = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc <= '0;
        end else if (push && acc_we) begin
            acc <= result;
        end
    end

    // Storage carries no reset; occupancy and pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= result;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign data_out_o = valid_o ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_soma_param_pipe.sv
// Bench for soma_param_pipe: directed scenarios plus randomized traffic
// checked against a queue-based result model.
module tb_soma_param_pipe;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          valid_i = 1'b0;
    logic          ready_o = 1'b0;
    logic [1:0]    op_i = 2'b00;
    logic [W-1:0]  data1_i = '0;
    logic [W-1:0]  data2_i = '0;
    logic          ready_i;
    logic          valid_o;
    logic [W:0]    data_out_o;
    logic [CW-1:0] count_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W:0] q[$];
    logic [W:0] macc = '0;

    soma_param_pipe #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk),
        .rstn(rstn),
        .valid_i(valid_i),
        .ready_i(ready_i),
        .op_i(op_i),
        .data1_i(data1_i),
        .data2_i(data2_i),
        .valid_o(valid_o),
        .ready_o(ready_o),
        .data_out_o(data_out_o),
        .count_o(count_o)
    );

    always #5 clk = ~clk;

    function automatic logic [W:0] ref_res(input logic [1:0] op,
                                           input int d1, input int d2);
        int r;
        case (op)
            2'd0: r = d1 + d2;
            2'd1: r = d1 - d2;
            2'd2: r = int'(macc) + d1;
            default: r = d1 + d2;
        endcase
        r = r & ((1 << (W + 1)) - 1);
        return r[W:0];
    endfunction

    // Drive one cycle from a negedge, advance the model, return at negedge.
    task automatic cycle(input bit v, input logic [1:0] op,
                         input int d1, input int d2, input bit r);
        bit push;
        bit pop;
        logic [W:0] res;
        valid_i = v;
        op_i    = op;
        data1_i = d1[W-1:0];
        data2_i = d2[W-1:0];
        ready_o = r;
        push = v && (q.size() < D);
        pop  = r && (q.size() > 0);
        res  = ref_res(op, d1 & 255, d2 & 255);
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (push) begin
            q.push_back(res);
            if (op[1]) macc = res;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (valid_o !== 1'b0 || count_o !== '0 || data_out_o !== '0
            || ready_i !== 1'b1) begin
            n_bad++;
            $display("FAIL reset: v=%b c=%0d d=%h r=%b want 0 0 0 1",
                     valid_o, count_o, data_out_o, ready_i);
        end
        rstn = 1'b1;
        q.delete();
        macc = '0;
    endtask

    task automatic test_add();
        cycle(1, 2'd0, 255, 255, 1);
        n_cmp++;
        if (valid_o !== 1'b1 || data_out_o !== 9'h1FE) begin
            n_bad++;
            $display("FAIL add_ff: v=%b d=%h want 1 1fe", valid_o, data_out_o);
        end
        cycle(0, 2'd0, 0, 0, 1);
        n_cmp++;
        if (valid_o !== 1'b0 || data_out_o !== 9'h000) begin
            n_bad++;
            $display("FAIL add_drain: v=%b d=%h want 0 000", valid_o, data_out_o);
        end
    endtask

    task automatic test_sub();
        cycle(1, 2'd1, 3, 5, 1);
        n_cmp++;
        if (data_out_o !== 9'h1FE) begin
            n_bad++;
            $display("FAIL sub_neg: got %h want 1fe", data_out_o);
        end
        cycle(1, 2'd1, 5, 3, 1);
        n_cmp++;
        if (data_out_o !== 9'h002) begin
            n_bad++;
            $display("FAIL sub_pos: got %h want 002", data_out_o);
        end
        cycle(0, 2'd0, 0, 0, 1);
    endtask

    task automatic test_acc();
        cycle(1, 2'd3, 255, 255, 1);
        n_cmp++;
        if (data_out_o !== 9'h1FE) begin
            n_bad++;
            $display("FAIL acc_load: got %h want 1fe", data_out_o);
        end
        cycle(1, 2'd2, 3, 99, 1);
        n_cmp++;
        if (data_out_o !== 9'h001) begin
            n_bad++;
            $display("FAIL acc_wrap: got %h want 001", data_out_o);
        end
        cycle(1, 2'd2, 16, 7, 1);
        n_cmp++;
        if (data_out_o !== 9'h011) begin
            n_bad++;
            $display("FAIL acc_add: got %h want 011", data_out_o);
        end
        cycle(0, 2'd0, 0, 0, 1);
    endtask

    task automatic test_backpressure();
        int a[5] = '{10, 20, 30, 40, 50};
        int b[5] = '{1, 2, 3, 4, 5};
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (ready_i !== (k < 4)) begin
                n_bad++;
                $display("FAIL bp_ready%0d: got %b want %b", k, ready_i, k < 4);
            end
            cycle(1, 2'd0, a[k], b[k], 0);
        end
        n_cmp++;
        if (count_o !== 3'd4 || ready_i !== 1'b0 || data_out_o !== 9'd11) begin
            n_bad++;
            $display("FAIL bp_full: c=%0d r=%b d=%h want 4 0 00b",
                     count_o, ready_i, data_out_o);
        end
        cycle(1, 2'd0, a[4], b[4], 1);
        n_cmp++;
        if (count_o !== 3'd3 || ready_i !== 1'b1 || data_out_o !== 9'd22) begin
            n_bad++;
            $display("FAIL bp_pop1: c=%0d r=%b d=%h want 3 1 016",
                     count_o, ready_i, data_out_o);
        end
        cycle(1, 2'd0, a[4], b[4], 1);
        for (int j = 2; j < 5; j++) begin
            n_cmp++;
            if (count_o !== CW'(5 - j) || data_out_o !== 9'(a[j] + b[j])) begin
                n_bad++;
                $display("FAIL bp_order%0d: c=%0d d=%h want %0d %h",
                         j, count_o, data_out_o, 5 - j, a[j] + b[j]);
            end
            cycle(0, 2'd0, 0, 0, 1);
        end
        n_cmp++;
        if (count_o !== '0 || valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_empty: c=%0d v=%b want 0 0", count_o, valid_o);
        end
    endtask

    task automatic test_simul();
        int pushed = 0;
        int popped = 0;
        cycle(1, 2'd0, $urandom_range(255), $urandom_range(255), 0);
        cycle(1, 2'd1, $urandom_range(255), $urandom_range(255), 0);
        for (int k = 0; k < 10; k++) begin
            logic [W:0] exp_d;
            exp_d = q[0];
            n_cmp++;
            if (count_o !== 3'd2 || data_out_o !== exp_d) begin
                n_bad++;
                $display("FAIL simul%0d: c=%0d d=%h want 2 %h",
                         k, count_o, data_out_o, exp_d);
            end
            cycle(1, 2'($urandom_range(1)), $urandom_range(255),
                  $urandom_range(255), 1);
            pushed++;
            popped++;
        end
        n_cmp++;
        if (count_o !== 3'd2 || pushed != popped) begin
            n_bad++;
            $display("FAIL simul_end: c=%0d want 2", count_o);
        end
        while (q.size() > 0) begin
            n_cmp++;
            if (data_out_o !== q[0]) begin
                n_bad++;
                $display("FAIL simul_drain: got %h want %h", data_out_o, q[0]);
            end
            cycle(0, 2'd0, 0, 0, 1);
        end
    endtask

    task automatic test_mid_reset();
        cycle(1, 2'd3, 8'h50, 8'h05, 0);
        cycle(1, 2'd0, 1, 2, 0);
        cycle(1, 2'd0, 3, 4, 0);
        n_cmp++;
        if (count_o !== 3'd3 || data_out_o !== 9'h055) begin
            n_bad++;
            $display("FAIL mr_pre: c=%0d d=%h want 3 055", count_o, data_out_o);
        end
        #2 rstn = 1'b0;
        #1;
        n_cmp++;
        if (valid_o !== 1'b0 || count_o !== '0 || data_out_o !== '0
            || ready_i !== 1'b1) begin
            n_bad++;
            $display("FAIL mr_async: v=%b c=%0d d=%h r=%b want 0 0 0 1",
                     valid_o, count_o, data_out_o, ready_i);
        end
        @(negedge clk);
        rstn = 1'b1;
        q.delete();
        macc = '0;
        cycle(1, 2'd2, 1, 200, 1);
        n_cmp++;
        if (valid_o !== 1'b1 || data_out_o !== 9'h001) begin
            n_bad++;
            $display("FAIL mr_acc: v=%b d=%h want 1 001", valid_o, data_out_o);
        end
        cycle(0, 2'd0, 0, 0, 1);
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            logic [W:0] exp_d;
            int sz;
            sz = q.size();
            exp_d = (sz != 0) ? q[0] : '0;
            n_cmp++;
            if (count_o !== CW'(sz) || valid_o !== (sz != 0)
                || ready_i !== (sz != D) || data_out_o !== exp_d) begin
                n_bad++;
                $display("FAIL rnd%0d: c=%0d v=%b r=%b d=%h want %0d %b %b %h",
                         k, count_o, valid_o, ready_i, data_out_o,
                         sz, sz != 0, sz != D, exp_d);
            end
            cycle($urandom_range(3) != 0, 2'($urandom_range(3)),
                  $urandom_range(255), $urandom_range(255),
                  $urandom_range(2) != 0);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_add();
        test_sub();
        test_acc();
        test_backpressure();
        test_simul();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
